usb_rx_ctrl: RTL and testbench

USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

---
 rtl/usb_rx_ctrl_if.sv | 34 +++
 rtl/usb_rx_ctrl.sv | 153 +++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_ctrl_if.sv
// USB RX controller bus bundle: bit-timer/line inputs, FIFO-side outputs.
// The slave modport is the controller; the master modport is its environment.
interface usb_rx_ctrl_if;
    logic       d_edge;
    logic       eop;
    logic       stuff_detect;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_byte;
    logic       fifo_full;
    logic       rcving;
    logic [3:0] bit_cnt;
    logic       shift_stop;
    logic       w_enable;
    logic [7:0] rcv_data;
    logic [3:0] pid;
    logic [6:0] byte_count;
    logic       rcv_done;
    logic       rx_error;

    modport slave (
        input  d_edge, eop, stuff_detect, shift_enable,
        input  byte_received, rcv_byte, fifo_full,
        output rcving, bit_cnt, shift_stop, w_enable,
        output rcv_data, pid, byte_count, rcv_done, rx_error
    );

    modport master (
        output d_edge, eop, stuff_detect, shift_enable,
        output byte_received, rcv_byte, fifo_full,
        input  rcving, bit_cnt, shift_stop, w_enable,
        input  rcv_data, pid, byte_count, rcv_done, rx_error
    );
endinterface

// File: rtl/usb_rx_ctrl.sv
// USB receive packet controller: SYNC/PID/DATA sequencing, FIFO writes, EOP.
// Optional macro USB_RX_PID_CHECK_EN enables the PID complement check.
module usb_rx_ctrl (
    input  logic          clk,
    input  logic          rst,
    usb_rx_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_EOP_WAIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t     state_q, state_d;
    logic       w_enable_q, w_enable_d;
    logic [7:0] rcv_data_q, rcv_data_d;
    logic [3:0] pid_q, pid_d;
    logic [6:0] byte_count_q, byte_count_d;
    logic       rx_error_q, rx_error_d;
    logic       partial_q, partial_d;
    logic       rcving;

    // Timer is enabled only while a packet body is being shifted in.
    assign rcving = (state_q == ST_SYNC) ||
                    (state_q == ST_PID)  ||
                    (state_q == ST_DATA);

    assign bus.rcving     = rcving;
    assign bus.bit_cnt    = rcving ? 4'd8 : 4'd0;
    assign bus.shift_stop = bus.stuff_detect & rcving;
    assign bus.w_enable   = w_enable_q;
    assign bus.rcv_data   = rcv_data_q;
    assign bus.pid        = pid_q;
    assign bus.byte_count = byte_count_q;
    assign bus.rcv_done   = (state_q == ST_DONE);
    assign bus.rx_error   = rx_error_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            w_enable_q   <= 1'b0;
            rcv_data_q   <= 8'd0;
            pid_q        <= 4'd0;
            byte_count_q <= 7'd0;
            rx_error_q   <= 1'b0;
            partial_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_enable_q   <= w_enable_d;
            rcv_data_q   <= rcv_data_d;
            pid_q        <= pid_d;
            byte_count_q <= byte_count_d;
            rx_error_q   <= rx_error_d;
            partial_q    <= partial_d;
        end
    end

    // Next-state logic; a byte strobe always wins over a same-cycle eop.
    always_comb begin
        state_d      = state_q;
        w_enable_d   = 1'b0;
        rcv_data_d   = rcv_data_q;
        pid_d        = pid_q;
        byte_count_d = byte_count_q;
        rx_error_d   = rx_error_q;
        partial_d    = partial_q;

        // Stuffed bit slots are not real data bits.
        if (bus.byte_received) begin
            partial_d = 1'b0;
        end else if ((state_q == ST_DATA) && bus.shift_enable &&
                     !bus.stuff_detect) begin
            partial_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                partial_d = 1'b0;
                if (bus.d_edge) begin
                    state_d      = ST_SYNC;
                    rx_error_d   = 1'b0;
                    byte_count_d = 7'd0;
                end
            end
            ST_SYNC: begin
                if (bus.byte_received) begin
                    if (bus.rcv_byte == 8'h80) begin
                        state_d = ST_PID;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else if (bus.eop) begin
                    state_d = ST_ERROR;
                end
            end
            ST_PID: begin
                if (bus.byte_received) begin
`ifdef USB_RX_PID_CHECK_EN
                    if (bus.rcv_byte[7:4] != ~bus.rcv_byte[3:0]) begin
                        state_d = ST_ERROR;
                    end else begin
                        pid_d   = bus.rcv_byte[3:0];
                        state_d = ST_DATA;
                    end
`else
                    pid_d   = bus.rcv_byte[3:0];
                    state_d = ST_DATA;
`endif
                end else if (bus.eop) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (bus.byte_received) begin
                    if ((byte_count_q == 7'd64) || bus.fifo_full) begin
                        state_d = ST_ERROR;
                    end else begin
                        w_enable_d   = 1'b1;
                        rcv_data_d   = bus.rcv_byte;
                        byte_count_d = byte_count_q + 7'd1;
                    end
                end else if (bus.eop) begin
                    state_d = partial_q ? ST_ERROR : ST_EOP_WAIT;
                end
            end
            ST_EOP_WAIT: begin
                if (!bus.eop) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (!bus.eop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_ERROR) begin
            rx_error_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed scoreboard bench for usb_rx_ctrl.
// Expected FIFO writes and done pulses are queued; a monitor pops them.
module tb_usb_rx_ctrl;
    logic clk;
    logic rst;

    usb_rx_ctrl_if bus ();

    usb_rx_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    localparam int K_WR   = 1;
    localparam int K_DONE = 2;

    ev_t sb[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    // Monitor: every output event must match the head of the queue.
    always @(negedge clk) begin
        if (bus.w_enable) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected got data %h want no write",
                         bus.rcv_data);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.kind != K_WR || mon_e.data !== bus.rcv_data) begin
                    n_fail++;
                    $display("FAIL wr_data got write %h want kind %0d data %h",
                             bus.rcv_data, mon_e.kind, mon_e.data);
                end
            end
        end
        if (bus.rcv_done) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected got rcv_done want none");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.kind != K_DONE) begin
                    n_fail++;
                    $display("FAIL done_order got rcv_done want kind %0d data %h",
                             mon_e.kind, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge();
        bus.d_edge = 1'b1;
        cyc();
        bus.d_edge = 1'b0;
    endtask

    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bus.shift_enable = 1'b1;
            cyc();
            bus.shift_enable = 1'b0;
            cyc();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bus.shift_enable  = 1'b1;
            bus.byte_received = (i == 7);
            bus.rcv_byte      = b;
            cyc();
            bus.shift_enable  = 1'b0;
            bus.byte_received = 1'b0;
            cyc();
        end
    endtask

    task automatic eop_seq();
        bus.eop = 1'b1;
        cyc();
        cyc();
        bus.eop = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_rcving"},     32'(bus.rcving),     32'd0);
        chk({tag, "_bit_cnt"},    32'(bus.bit_cnt),    32'd0);
        chk({tag, "_w_enable"},   32'(bus.w_enable),   32'd0);
        chk({tag, "_rcv_done"},   32'(bus.rcv_done),   32'd0);
        chk({tag, "_rx_error"},   32'(bus.rx_error),   32'd0);
        chk({tag, "_rcv_data"},   32'(bus.rcv_data),   32'd0);
        chk({tag, "_pid"},        32'(bus.pid),        32'd0);
        chk({tag, "_byte_count"}, 32'(bus.byte_count), 32'd0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.d_edge        = 1'b0;
        bus.eop           = 1'b0;
        bus.stuff_detect  = 1'b0;
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        bus.rcv_byte      = 8'h00;
        bus.fifo_full     = 1'b0;
        cyc();
        cyc();
        all_zero("reset");
        chk("reset_shift_stop", 32'(bus.shift_stop), 32'd0);
        rst = 1'b0;
        cyc();

        // Clean packet 80/C3/11/22.
        pulse_edge();
        chk("sync_rcving", 32'(bus.rcving), 32'd1);
        chk("sync_bit_cnt", 32'(bus.bit_cnt), 32'd8);
        send_byte(8'h80);
        send_byte(8'hC3);
        chk("clean_pid", 32'(bus.pid), 32'd3);
        push(K_WR, 8'h11);
        send_byte(8'h11);
        push(K_WR, 8'h22);
        send_byte(8'h22);
        push(K_DONE, 8'h00);
        bus.eop = 1'b1;
        cyc();
        chk("eopwait_rcving", 32'(bus.rcving), 32'd0);
        chk("eopwait_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        cyc();
        bus.eop = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("clean_byte_count", 32'(bus.byte_count), 32'd2);
        chk("clean_rx_error", 32'(bus.rx_error), 32'd0);

        // Bad sync byte.
        pulse_edge();
        send_byte(8'h81);
        cyc();
        chk("badsync_rx_error", 32'(bus.rx_error), 32'd1);
        chk("badsync_rcving", 32'(bus.rcving), 32'd0);

        // PID byte C4.
        pulse_edge();
        chk("edge_clears_error", 32'(bus.rx_error), 32'd0);
        send_byte(8'h80);
        send_byte(8'hC4);
`ifdef USB_RX_PID_CHECK_EN
        chk("pidchk_rx_error", 32'(bus.rx_error), 32'd1);
        eop_seq();
`else
        chk("pid_c4_pid", 32'(bus.pid), 32'd4);
        chk("pid_c4_rx_error", 32'(bus.rx_error), 32'd0);
        chk("pid_c4_rcving", 32'(bus.rcving), 32'd1);
        push(K_DONE, 8'h00);
        eop_seq();
`endif

        // FIFO full at the second data byte.
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        push(K_WR, 8'hAA);
        send_byte(8'hAA);
        bus.fifo_full = 1'b1;
        send_byte(8'hBB);
        bus.fifo_full = 1'b0;
        chk("full_rx_error", 32'(bus.rx_error), 32'd1);
        chk("full_byte_count", 32'(bus.byte_count), 32'd1);
        eop_seq();

        // Stuffed slot is not a partial bit; d_edge ignored in DATA.
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        push(K_WR, 8'h66);
        send_byte(8'h66);
        pulse_edge();
        chk("dedge_ignored_count", 32'(bus.byte_count), 32'd1);
        bus.stuff_detect = 1'b1;
        bus.shift_enable = 1'b1;
        #1;
        chk("stuff_shift_stop", 32'(bus.shift_stop), 32'd1);
        cyc();
        bus.stuff_detect = 1'b0;
        bus.shift_enable = 1'b0;
        push(K_DONE, 8'h00);
        eop_seq();
        chk("stuff_eop_rx_error", 32'(bus.rx_error), 32'd0);
        bus.stuff_detect = 1'b1;
        #1;
        chk("idle_shift_stop", 32'(bus.shift_stop), 32'd0);
        bus.stuff_detect = 1'b0;

        // eop after three partial bits.
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        push(K_WR, 8'h55);
        send_byte(8'h55);
        shift_bits(3);
        eop_seq();
        chk("partial_rx_error", 32'(bus.rx_error), 32'd1);

        // 64-byte cap.
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        for (int i = 0; i < 64; i++) begin
            push(K_WR, 8'(i + 1));
            send_byte(8'(i + 1));
        end
        chk("cap_count_64", 32'(bus.byte_count), 32'd64);
        chk("cap_no_error", 32'(bus.rx_error), 32'd0);
        send_byte(8'hEE);
        chk("cap_rx_error", 32'(bus.rx_error), 32'd1);
        chk("cap_count_held", 32'(bus.byte_count), 32'd64);
        eop_seq();

        // Reset mid-DATA, coinciding with a byte strobe.
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        push(K_WR, 8'h77);
        send_byte(8'h77);
        shift_bits(7);
        bus.shift_enable  = 1'b1;
        bus.byte_received = 1'b1;
        bus.rcv_byte      = 8'h88;
        rst               = 1'b1;
        cyc();
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        all_zero("midrst");
        rst = 1'b0;
        cyc();

        // Clean packet after reset; last byte and eop coincide.
        pulse_edge();
        send_byte(8'h80);
        send_byte(8'hC3);
        push(K_WR, 8'h11);
        send_byte(8'h11);
        push(K_WR, 8'h22);
        push(K_DONE, 8'h00);
        for (int i = 0; i < 7; i++) begin
            bus.shift_enable = 1'b1;
            cyc();
            bus.shift_enable = 1'b0;
            cyc();
        end
        bus.shift_enable  = 1'b1;
        bus.byte_received = 1'b1;
        bus.rcv_byte      = 8'h22;
        bus.eop           = 1'b1;
        cyc();
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        cyc();
        bus.eop = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("post_count", 32'(bus.byte_count), 32'd2);
        chk("post_pid", 32'(bus.pid), 32'd3);
        chk("post_rx_error", 32'(bus.rx_error), 32'd0);

        cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
